// File: rtl/log_antilog_mul_pipe.sv
// log_antilog_mul_pipe: Mitchell approximate multiply back end (log add, antilog shift, sign)
// as a 3-stage valid/ready pipeline with a single global advance.
module log_antilog_mul_pipe #(
    parameter int FW = 12,
    parameter int CW = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CW-1:0]           a_pos,
    input  logic [FW-1:0]           a_frac,
    input  logic                    a_nz,
    input  logic                    a_sign,
    input  logic [CW-1:0]           b_pos,
    input  logic [FW-1:0]           b_frac,
    input  logic                    b_nz,
    input  logic                    b_sign,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2**(CW+1)-1:0]    prod_mag,
    output logic                    prod_sign,
    output logic                    busy
);
    localparam int OW = 2**(CW+1);

    logic          adv;
    logic          s1v_q, s2v_q, s3v_q;
    logic [FW-1:0] s1_fs_q;
    logic [CW:0]   s1_ch_q;
    logic          s1_z_q, s1_sg_q;
    logic [OW-1:0] s2_prod_q, prod_mag_q;
    logic          s2_sg_q, prod_sign_q;

    logic [FW:0]      s1_sum_d;
    logic [CW:0]      s1_ch_d;
    logic [FW+OW-1:0] s2_wide_d;
    logic [OW-1:0]    s2_prod_d;
    logic             s2_sg_d;

    assign adv       = ~s3v_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = s3v_q;
    assign busy      = s1v_q | s2v_q | s3v_q;
    assign prod_mag  = prod_mag_q;
    assign prod_sign = prod_sign_q;

    // Fraction carry folds into the characteristic; max 15+15+1 = 31 fits CW+1 bits.
    assign s1_sum_d = {1'b0, a_frac} + {1'b0, b_frac};
    assign s1_ch_d  = {1'b0, a_pos} + {1'b0, b_pos} + {{CW{1'b0}}, s1_sum_d[FW]};

    assign s2_wide_d = {{(OW-1){1'b0}}, 1'b1, s1_fs_q} << s1_ch_q;
    assign s2_prod_d = s1_z_q ? '0 : OW'(s2_wide_d >> FW);
    assign s2_sg_d   = ~s1_z_q & s1_sg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1v_q       <= 1'b0;
            s2v_q       <= 1'b0;
            s3v_q       <= 1'b0;
            s1_fs_q     <= '0;
            s1_ch_q     <= '0;
            s1_z_q      <= 1'b0;
            s1_sg_q     <= 1'b0;
            s2_prod_q   <= '0;
            s2_sg_q     <= 1'b0;
            prod_mag_q  <= '0;
            prod_sign_q <= 1'b0;
        end else if (adv) begin
            s1v_q       <= in_valid;
            s1_fs_q     <= s1_sum_d[FW-1:0];
            s1_ch_q     <= s1_ch_d;
            s1_z_q      <= ~(a_nz & b_nz);
            s1_sg_q     <= a_sign ^ b_sign;
            s2v_q       <= s1v_q;
            s2_prod_q   <= s2_prod_d;
            s2_sg_q     <= s2_sg_d;
            s3v_q       <= s2v_q;
            prod_mag_q  <= s2_prod_q;
            prod_sign_q <= s2_sg_q;
        end
    end
endmodule

// File: tb/tb_log_antilog_mul_pipe.sv
// tb_log_antilog_mul_pipe: table-driven vectors through a scoreboard queue, plus
// stall and mid-stream reset sequences.
module tb_log_antilog_mul_pipe;
    typedef struct {
        logic [3:0]  ap;
        logic [11:0] af;
        logic        an, as;
        logic [3:0]  bp;
        logic [11:0] bf;
        logic        bn, bs;
        logic [31:0] em;
        logic        es;
    } vec_t;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, busy, prod_sign;
    logic [3:0]  a_pos, b_pos;
    logic [11:0] a_frac, b_frac;
    logic        a_nz, a_sign, b_nz, b_sign;
    logic [31:0] prod_mag;

    int checks = 0;
    int failures = 0;
    logic [32:0] q[$];
    logic [32:0] popped;
    vec_t v[8];

    log_antilog_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_pos(a_pos), .a_frac(a_frac), .a_nz(a_nz), .a_sign(a_sign),
        .b_pos(b_pos), .b_frac(b_frac), .b_nz(b_nz), .b_sign(b_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod_mag(prod_mag), .prod_sign(prod_sign), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs are compared against the head of the scoreboard every valid cycle,
    // so a held (stalled) result is rechecked each cycle it stays up.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h/%0b expected none at %0t", prod_mag, prod_sign, $time);
            end else begin
                chk("prod_mag", prod_mag, q[0][31:0]);
                chk("prod_sign", {31'b0, prod_sign}, {31'b0, q[0][32]});
                if (out_ready) popped = q.pop_front();
            end
        end
    end

    task automatic send(input vec_t x);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_valid = 1;
        a_pos = x.ap; a_frac = x.af; a_nz = x.an; a_sign = x.as;
        b_pos = x.bp; b_frac = x.bf; b_nz = x.bn; b_sign = x.bs;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) q.push_back({x.es, x.em});
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 50 cycles");
        end
        in_valid = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        v[0] = '{4'd1,  12'h800, 1, 0, 4'd1,  12'h800, 1, 0, 32'd8,        0};
        v[1] = '{4'd2,  12'h400, 1, 1, 4'd1,  12'h800, 1, 0, 32'd14,       1};
        v[2] = '{4'd15, 12'hFFF, 1, 0, 4'd15, 12'hFFF, 1, 0, 32'hFFF00000, 0};
        v[3] = '{4'd0,  12'h000, 1, 0, 4'd0,  12'h000, 1, 0, 32'd1,        0};
        v[4] = '{4'd3,  12'hA5A, 0, 1, 4'd2,  12'h123, 1, 0, 32'd0,        0};
        v[5] = '{4'd0,  12'h800, 1, 1, 4'd0,  12'h800, 1, 1, 32'd2,        0};
        v[6] = '{4'd4,  12'h000, 1, 0, 4'd5,  12'h000, 1, 1, 32'd512,      1};
        v[7] = '{4'd7,  12'h0C0, 1, 1, 4'd3,  12'h300, 1, 1, 32'h4F0,      0};

        rst = 1; in_valid = 0; out_ready = 1;
        a_pos = 0; a_frac = 0; a_nz = 0; a_sign = 0;
        b_pos = 0; b_frac = 0; b_nz = 0; b_sign = 0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_prod_mag", prod_mag, 0);
        chk("rst_prod_sign", {31'b0, prod_sign}, 0);
        @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 8; i++) send(v[i]);
        drain();

        fork
            for (int i = 0; i < 8; i++) send(v[7 - i]);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'b0, in_ready}, 0);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();

        out_ready = 0;
        send(v[1]);
        send(v[2]);
        send(v[3]);
        chk("inflight_busy", {31'b0, busy}, 1);
        chk("inflight_out_valid", {31'b0, out_valid}, 1);
        rst = 1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_prod_mag", prod_mag, 0);
        q.delete();
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        send(v[0]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
